// File: rtl/alu_issue.sv
// Single-issue front end for an external multi-cycle ALU: owns an 8x16 register
// file, issues one instruction at a time and writes the ALU result back.
module alu_issue #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [2:0]  instr_dst,
  input  logic [2:0]  instr_srca,
  input  logic [2:0]  instr_srcb,
  output logic [2:0]  alu_control,
  output logic        alu_load,
  output logic [15:0] alu_din_a,
  output logic [15:0] alu_din_b,
  input  logic        alu_valid,
  input  logic [15:0] alu_dout,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   regs [8];
  logic [2:0]    op_q, dst_q, srca_q, srcb_q;
  logic          accept, wb_en, fin, fin_err;
  logic          done_q, err_q;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      done_q   <= fin;
      err_q    <= fin_err;
    end
  end

  // Instruction fields are only consumed after a qualified accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= instr_op;
      dst_q  <= instr_dst;
      srca_q <= instr_srca;
      srcb_q <= instr_srcb;
    end
  end

  // NOTE: the register file is cleared by reset because software reads R0..R7
  // straight after reset and expects zeros; most RAM-like arrays stay unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[dst_q] <= alu_dout;
    end else if (wr_en && state == S_IDLE) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    wb_en       = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    instr_ready = 1'b0;
    alu_load    = 1'b0;
    alu_control = '0;
    alu_din_a   = '0;
    alu_din_b   = '0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept = 1'b1;
          if (op_legal(instr_op)) begin
            next_state = S_ISSUE;
          end else begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        alu_load    = 1'b1;
        alu_control = op_q;
        alu_din_a   = regs[srca_q];
        alu_din_b   = regs[srcb_q];
        next_state  = S_WAIT;
      end
      S_WAIT: begin
        if (alu_valid) begin
          wb_en      = 1'b1;
          fin        = 1'b1;
          next_state = S_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          fin        = 1'b1;
          fin_err    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    // Outputs read as inactive for the whole reset cycle, not just after the edge.
    if (reset) begin
      accept      = 1'b0;
      wb_en       = 1'b0;
      fin         = 1'b0;
      fin_err     = 1'b0;
      instr_ready = 1'b0;
      alu_load    = 1'b0;
      alu_control = '0;
      alu_din_a   = '0;
      alu_din_b   = '0;
    end
  end

  assign rd_data = regs[rd_addr];
  assign busy    = (state != S_IDLE) && !reset;
  assign done    = done_q && !reset;
  assign err     = err_q && done_q && !reset;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: the bench plays the external ALU, keeps a shadow
// register file and a scoreboard of expected completions.
module tb_alu_issue;

  localparam int WAIT_LIMIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op, instr_dst, instr_srca, instr_srcb;
  logic [2:0]  alu_control;
  logic        alu_load;
  logic [15:0] alu_din_a, alu_din_b;
  logic        alu_valid;
  logic [15:0] alu_dout;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy, done, err;

  alu_issue #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst),
    .instr_srca(instr_srca), .instr_srcb(instr_srcb),
    .alu_control(alu_control), .alu_load(alu_load),
    .alu_din_a(alu_din_a), .alu_din_b(alu_din_b),
    .alu_valid(alu_valid), .alu_dout(alu_dout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        wb;
    logic [2:0]  dst;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [8];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] prod;
    prod = a * b;
    case (op)
      3'b001:  return a + b;
      3'b010:  return b - a;
      3'b011:  return prod[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_reg(input string tag, input int idx);
    rd_addr = 3'(idx);
    #1;
    check($sformatf("%s_r%0d", tag, idx), rd_data, shadow[idx]);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) check_reg(tag, i);
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    shadow[addr] = data;
  endtask

  // Called at a negedge where done is expected: pops the oldest expectation.
  task automatic pop_done(input string tag);
    exp_t e;
    check({tag, "_pending"}, sb.size(), 1);
    check({tag, "_done"}, done, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_err"}, err, e.err);
      if (e.wb) shadow[e.dst] = e.val;
      check_reg(tag, int'(e.dst));
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, err}, 2'b00);
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] dst,
                       input logic [2:0] sa, input logic [2:0] sb_idx,
                       input bit stale, input bit do_wr,
                       input logic [2:0] waddr, input logic [15:0] wdata);
    exp_t e;
    logic legal;
    @(negedge clk);
    check({tag, "_ready"}, instr_ready, 1'b1);
    instr_valid = 1'b1; instr_op = op; instr_dst = dst; instr_srca = sa; instr_srcb = sb_idx;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
      shadow[waddr] = wdata;
    end
    legal = op inside {3'b001, 3'b010, 3'b011};
    e.err = !legal;
    e.wb  = legal;
    e.dst = dst;
    e.val = alu_model(op, shadow[sa], shadow[sb_idx]);
    sb.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0; wr_en = 1'b0;
    if (!legal) begin
      check({tag, "_no_load"}, alu_load, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      pop_done(tag);
      return;
    end
    check({tag, "_load"}, alu_load, 1'b1);
    check({tag, "_ctrl"}, alu_control, op);
    check({tag, "_din_a"}, alu_din_a, shadow[sa]);
    check({tag, "_din_b"}, alu_din_b, shadow[sb_idx]);
    if (stale) begin
      alu_valid = 1'b1; alu_dout = ~e.val;
    end
    @(negedge clk);
    check({tag, "_load_off"}, {alu_load, alu_din_a, alu_din_b}, 33'd0);
    alu_valid = 1'b1; alu_dout = e.val;
    @(negedge clk);
    alu_valid = 1'b0; alu_dout = 16'h0;
    check({tag, "_ready_back"}, instr_ready, 1'b1);
    pop_done(tag);
  endtask

  initial begin
    int n;
    exp_t e;
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0; instr_srca = '0;
    instr_srcb = '0; alu_valid = 1'b0; alu_dout = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_outputs", {instr_ready, alu_load, alu_control, busy, done, err}, 8'd0);
    check("rst_din", {alu_din_a, alu_din_b}, 32'd0);
    check_all_regs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", instr_ready, 1'b1);
    check("rst_release_busy", busy, 1'b0);

    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    issue("add", 3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);

    host_write(3'd1, 16'h0002);
    host_write(3'd2, 16'h0007);
    issue("sub", 3'b010, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
    issue("mul_sq", 3'b011, 3'd4, 3'd2, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);

    host_write(3'd1, 16'h0300);
    host_write(3'd2, 16'h0100);
    issue("mul_trunc", 3'b011, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
    host_write(3'd6, 16'h0001);
    host_write(3'd7, 16'h0000);
    issue("sub_wrap", 3'b010, 3'd0, 3'd6, 3'd7, 1'b1, 1'b0, 3'd0, 16'h0);

    issue("ill_000", 3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
    issue("ill_111", 3'b111, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
    check_all_regs("ill_regs");

    issue("wr_accept", 3'b001, 3'd6, 3'd1, 3'd4, 1'b0, 1'b1, 3'd1, 16'h0010);

    // A result strobe while idle must be ignored.
    @(negedge clk);
    alu_valid = 1'b1; alu_dout = 16'h1234;
    @(negedge clk);
    alu_valid = 1'b0;
    check("idle_valid", {done, busy}, 2'b00);
    check_all_regs("idle_valid");

    // Timeout: ALU never answers; a host write during WAIT is dropped.
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b001; instr_dst = 3'd2; instr_srca = 3'd1; instr_srcb = 3'd1;
    e.err = 1'b1; e.wb = 1'b0; e.dst = 3'd2; e.val = 16'h0;
    sb.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    check("to_load", alu_load, 1'b1);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    n = 0;
    while (!done && n < WAIT_LIMIT + 5) begin
      @(negedge clk);
      n++;
      if (n == 1) wr_en = 1'b0;
    end
    check("to_latency", n, WAIT_LIMIT);
    pop_done("timeout");
    check_reg("to_busy_wr", 3);

    // Reset while waiting abandons the instruction.
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b011; instr_dst = 3'd7; instr_srca = 3'd1; instr_srcb = 3'd2;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("wr_busy", busy, 1'b1);
    reset = 1'b1; alu_valid = 1'b1; alu_dout = 16'h7777;
    @(negedge clk);
    check("mid_rst_outputs", {instr_ready, alu_load, busy, done, err}, 5'd0);
    reset = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    @(negedge clk);
    check("mid_rst_ready", instr_ready, 1'b1);
    check("mid_rst_no_done", {done, err}, 2'b00);
    check_all_regs("mid_rst");
    @(negedge clk);
    check("mid_rst_no_done_late", {done, err, busy}, 3'b000);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
